// File: rtl/nios2_c_rstseq_pkg.sv
// rtl/nios2_c_rstseq_pkg.sv - shared state, register map and bit positions for the reset sequencer
package nios2_c_rstseq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [1:0] ADDR_STATUS = 2'd0;
    localparam logic [1:0] ADDR_CAUSE  = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CMD    = 2'd3;

    localparam int CAUSE_SW   = 8;
    localparam int CAUSE_WDT  = 9;
    localparam int CAUSE_POR  = 31;
    localparam int IRQ_EN     = 16;
    localparam int STAT_STATE = 8;
    localparam int STAT_BUSY  = 16;

endpackage

// File: rtl/nios2_c_rstseq_debounce.sv
// rtl/nios2_c_rstseq_debounce.sv - 2-flop synchronizer plus saturating debounce counter, 1 bit
module nios2_c_rstseq_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic accepted
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(DEBOUNCE_CYCLES);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (!sync2)
                cnt <= '0;
            else if (cnt != SAT)
                cnt <= cnt + 1'b1;
        end
    end

    assign accepted = (cnt == SAT);

endmodule

// File: rtl/nios2_c_reset_sequencer.sv
// rtl/nios2_c_reset_sequencer.sv - staged reset controller with cause register and Avalon-MM slave
// Optional watchdog: define RSTSEQ_WATCHDOG_EN.
module nios2_c_reset_sequencer
    import nios2_c_rstseq_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int NUM_STAGES      = 3,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 64,
    parameter int STAGE_GAP       = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_in,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic                  irq,
    output logic [NUM_STAGES-1:0] rst_out,
    output logic                  busy
);

    localparam int HCW = $clog2(HOLD_CYCLES + 1);
    localparam int GCW = $clog2(STAGE_GAP + 1);
    localparam int ICW = $clog2(NUM_STAGES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(STAGE_GAP - 1);
    localparam logic [ICW-1:0] IDX_LAST  = ICW'(NUM_STAGES - 1);

    state_t                  state, state_nxt;
    logic [HCW-1:0]          hold_cnt, hold_nxt;
    logic [GCW-1:0]          gap_cnt, gap_nxt;
    logic [ICW-1:0]          idx, idx_nxt;
    logic [NUM_STAGES-1:0]   rst_nxt;
    logic [NUM_REQ-1:0]      accepted;
    logic [NUM_REQ-1:0]      req_en;
    logic                    irq_en;
    logic                    sw_pulse;
    logic                    wdt_trig;
    logic                    trig;
    logic                    wr;
    logic [31:0]             cause, cause_set, cause_clr, rd_mux;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_deb
        nios2_c_rstseq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .clk      (clk),
            .reset    (reset),
            .din      (req_in[i]),
            .accepted (accepted[i])
        );
    end

    assign wr   = chipselect && !write_n;
    assign trig = (|(accepted & req_en)) || sw_pulse || wdt_trig;
    assign busy = |rst_out;

`ifdef RSTSEQ_WATCHDOG_EN
    logic [23:0] wdt_cnt;
    logic        kick;

    assign kick     = wr && (address == ADDR_CMD) && writedata[1];
    assign wdt_trig = (state == ST_IDLE) && (wdt_cnt == 24'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            wdt_cnt <= 24'hFFFFFF;
        else if (kick || (state_nxt == ST_IDLE && state != ST_IDLE))
            wdt_cnt <= 24'hFFFFFF;
        else if (state == ST_IDLE && wdt_cnt != 24'd0)
            wdt_cnt <= wdt_cnt - 24'd1;
    end
`else
    assign wdt_trig = 1'b0;
`endif

    // Any trigger restarts the whole hold from zero, whatever the current state.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        gap_nxt   = gap_cnt;
        idx_nxt   = idx;
        rst_nxt   = rst_out;
        if (trig) begin
            state_nxt = ST_HOLD;
            hold_nxt  = '0;
            gap_nxt   = '0;
            idx_nxt   = '0;
            rst_nxt   = '1;
        end else begin
            case (state)
                ST_HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        rst_nxt[0] = 1'b0;
                        idx_nxt    = ICW'(1);
                        gap_nxt    = '0;
                        state_nxt  = (NUM_STAGES == 1) ? ST_IDLE : ST_RELEASE;
                    end else begin
                        hold_nxt = hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (gap_cnt == GAP_LAST) begin
                        for (int k = 0; k < NUM_STAGES; k++)
                            if (idx == ICW'(k))
                                rst_nxt[k] = 1'b0;
                        gap_nxt = '0;
                        idx_nxt = idx + 1'b1;
                        if (idx == IDX_LAST)
                            state_nxt = ST_IDLE;
                    end else begin
                        gap_nxt = gap_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        cause_set                = '0;
        cause_set[NUM_REQ-1:0]   = accepted & req_en;
        cause_set[CAUSE_SW]      = sw_pulse;
        cause_set[CAUSE_WDT]     = wdt_trig;
        cause_clr                = (wr && address == ADDR_CAUSE) ? writedata : 32'd0;
    end

    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_STATUS: begin
                rd_mux[NUM_REQ-1:0]             = accepted;
                rd_mux[STAT_STATE+1:STAT_STATE] = state;
                rd_mux[STAT_BUSY]               = busy;
            end
            ADDR_CAUSE: rd_mux = cause;
            ADDR_CTRL: begin
                rd_mux[NUM_REQ-1:0] = req_en;
                rd_mux[IRQ_EN]      = irq_en;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            rst_out  <= '1;
            cause    <= 32'h1 << CAUSE_POR;
            req_en   <= '1;
            irq_en   <= 1'b0;
            sw_pulse <= 1'b0;
            irq      <= 1'b0;
            readdata <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            gap_cnt  <= gap_nxt;
            idx      <= idx_nxt;
            rst_out  <= rst_nxt;
            // Set wins over a simultaneous write-1-to-clear.
            cause    <= (cause & ~cause_clr) | cause_set;
            if (wr && address == ADDR_CTRL) begin
                req_en <= writedata[NUM_REQ-1:0];
                irq_en <= writedata[IRQ_EN];
            end
            sw_pulse <= wr && (address == ADDR_CMD) && writedata[0];
            irq      <= irq_en && (cause != 32'd0);
            if (chipselect && write_n)
                readdata <= rd_mux;
        end
    end

endmodule

// File: doc/nios2_c_reset_sequencer.md
Name: nios2_c_reset_sequencer

Overview:
Central reset controller for the Nios II subsystem.
- Collects asynchronous hardware reset requests (push-button, PLL-unlock, debug) plus a software trigger.
- Holds a fixed number of downstream reset stages asserted, then releases them in order with programmable spacing.
- Records the cause of each reset in a sticky register readable over an Avalon-MM slave (s1), and raises an IRQ.

Parameters:
NUM_REQ, 4, number of hardware request inputs (1..8)
NUM_STAGES, 3, number of sequenced reset outputs (1..8)
DEBOUNCE_CYCLES, 16, consecutive synced-high cycles before a request is accepted (>=1)
HOLD_CYCLES, 64, cycles all stages stay asserted after the last accepted request
STAGE_GAP, 8, cycles between successive stage releases (>=1)

Ports:
clk  in  1  system clock; the only clock
reset  in  1  asynchronous, active-high reset of the sequencer itself
req_in  in  NUM_REQ  asynchronous active-high reset requests
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active low
writedata  in  32  Avalon write data
readdata  out  32  registered read data
irq  out  1  level interrupt
rst_out  out  NUM_STAGES  active-high stage resets; bit 0 is released first
busy  out  1  high whenever any stage is asserted

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high. All flops reset asynchronously.
- Reset values:
  - rst_out = all ones, busy = 1, readdata = 0, irq = 0.
  - State = HOLD, hold counter = 0.
  - cause = bit 31 only (power-on flag).
  - req_en = all ones, irq_en = 0.
- Request input path:
  - Each req_in bit passes through a 2-flop synchronizer, then a per-bit debounce counter.
  - The counter clears whenever the synced bit is 0. "Accepted" is high while the counter has saturated at DEBOUNCE_CYCLES.
- Trigger: trig = |(accepted & req_en) | sw_pulse.
- FSM states:
  - IDLE: rst_out = 0. On trig go to HOLD, set rst_out = all ones on the next edge, clear counters.
  - HOLD: rst_out = all ones. Counter increments each cycle and restarts at 0 on any trig. On reaching HOLD_CYCLES-1 go to RELEASE with stage index 0.
  - RELEASE: every STAGE_GAP cycles clear rst_out[idx] and increment idx. Stage 0 clears on the first RELEASE cycle. After bit NUM_STAGES-1 clears, go to IDLE.
  - A trig during RELEASE returns to HOLD and re-asserts all stages on the next edge.
- Stage release timing: from the last trig cycle, stage k releases after HOLD_CYCLES + k*STAGE_GAP + 1 cycles.
- busy = |rst_out.
- cause (sticky) is set on every trig:
  - bit i set for each accepted and enabled req i;
  - bit 8 for software trigger;
  - bit 9 for watchdog.
  - Set has priority over clear in the same cycle.
- Registers (read data is registered, 1-cycle latency; writes take effect the cycle after the strobe):
  - addr0 status, RO: [NUM_REQ-1:0] accepted levels, [9:8] state (0 IDLE, 1 HOLD, 2 RELEASE), [16] busy.
  - addr1 cause, write-1-to-clear.
  - addr2 control, RW: [NUM_REQ-1:0] req_en, [16] irq_en.
  - addr3 command, WO, reads 0: bit0 = 1 generates a one-cycle sw_pulse; bit1 = watchdog kick.
- irq = irq_en & (cause != 0), registered.
- Unused read bits return 0.

Optional Feature:
RSTSEQ_WATCHDOG_EN:
- Defined:
  - Adds a 24-bit down-counter loaded with 24'hFFFFFF on reset, on each kick and on entering IDLE. It decrements only in IDLE.
  - Reaching 0 generates trig and sets cause bit 9.
  - addr3 bit1 is a kick.
- Undefined: no counter; kick writes are ignored; cause bit 9 always reads 0.

Decomposition:
- Shared package nios2_c_rstseq_pkg holds:
  - state enum;
  - register address constants (ADDR_STATUS=0, ADDR_CAUSE=1, ADDR_CTRL=2, ADDR_CMD=3);
  - cause bit positions (CAUSE_SW=8, CAUSE_WDT=9, CAUSE_POR=31);
  - control bit IRQ_EN=16.
- One sub-module: nios2_c_rstseq_debounce (2-flop sync plus saturating counter, 1 bit). It is instantiated NUM_REQ times with a generate loop.

Test Plan:
- Power-on: deassert reset at cycle 0, defaults otherwise.
  → rst_out = 3'b111 until cycle 64; bit0 drops at 64, bit1 at 72, bit2 at 80; cause reads 32'h8000_0000.
- Request debounce: req_in[1] high for 10 cycles → no trig. Then high for 20 cycles → HOLD entered 18 cycles after the rising edge (2 sync + 16 debounce); cause bit1 set.
- Masking: write addr2 = 32'h0001_000D, pulse req_in[1] → no reset, cause unchanged. Then pulse req_in[0] → reset sequence, irq = 1; write addr1 = 1 → irq = 0.
- Restart: software trigger (addr3 = 1) while in RELEASE after stage0 released → all stages re-asserted next cycle; full HOLD_CYCLES restarts.
- Cause clear races: write addr1 = 32'hFFFF_FFFF in the same cycle as a new trig from req 2 → cause reads 32'h0000_0004.
- With RSTSEQ_WATCHDOG_EN defined: no kicks in IDLE → trig after 2^24-1 cycles, cause bit9 set. Periodic kicks every 1000 cycles → no trig.
